// File: rtl/uart_tx_serializer_pkg.sv
// Shared definitions for the UART transmit path: FSM state encoding,
// line idle level and the baud divisor helper.
package uart_tx_serializer_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_CAPTURE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } tx_state_t;

    localparam logic UART_IDLE_LEVEL = 1'b1;

    // Rounded clock cycles per bit for a given clock and baud rate.
    function automatic int calc_clks_per_bit(input longint clk_hz, input longint baud_hz);
        return int'((clk_hz + baud_hz / 2) / baud_hz);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while enabled and flags the
// last cycle of each bit period. Shared by the TX and future RX blocks.
module uart_baud_tick #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            clr,
    input  logic                            en,
    output logic                            tick,
    output logic [$clog2(CLKS_PER_BIT)-1:0] count
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    assign tick = en && (count == LAST);

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= tick ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmitter fed from the byte FIFO: pops one byte per frame and sends
// start, LSB-first data, optional parity and stop bits, carrying the last flag.
module uart_tx_serializer
    import uart_tx_serializer_pkg::*;
#(
    parameter int CLKS_PER_BIT = calc_clks_per_bit(100_000_000, 115_200),
    parameter int DATA_BITS    = 8,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 fifo_empty,
    output logic                 fifo_rd_en,
    input  logic [DATA_BITS-1:0] fifo_dout,
    input  logic                 fifo_dout_last,
    output logic                 tx,
    output logic                 busy,
    output logic                 byte_done,
    output logic                 pkt_done
);

    localparam int CW   = $clog2(CLKS_PER_BIT);
    localparam int BC_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [BC_W-1:0] DATA_LAST = BC_W'(DATA_BITS - 1);
    localparam logic [BC_W-1:0] STOP_LAST = BC_W'(STOP_BITS - 1);
    localparam logic [CW-1:0]   CNT_PRE   = CW'(CLKS_PER_BIT - 2);
    localparam logic            ODD       = (PARITY_ODD != 0);

    tx_state_t             state_q, state_d;
    logic [DATA_BITS-1:0]  shift_q, shift_d;
    logic [BC_W-1:0]       bit_cnt_q, bit_cnt_d;
    logic                  last_q, last_d;
    logic                  parity_q, parity_d;
    logic                  tx_d, rd_en_d, byte_done_d, pkt_done_d;
    logic                  tick, baud_en, baud_clr;
    logic [CW-1:0]         baud_cnt;

    assign busy     = (state_q != S_IDLE);
    assign baud_en  = (state_q inside {S_START, S_DATA, S_PARITY, S_STOP});
    assign baud_clr = (state_q == S_CAPTURE);

    uart_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk  (clk),
        .rst  (rst),
        .clr  (baud_clr),
        .en   (baud_en),
        .tick (tick),
        .count(baud_cnt)
    );

    // NOTE: every signal driven here gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        last_d    = last_q;
        parity_d  = parity_q;
        case (state_q)
            S_IDLE:    if (!fifo_empty) state_d = S_FETCH;
            S_FETCH:   state_d = S_CAPTURE;
            S_CAPTURE: begin
                shift_d   = fifo_dout;
                last_d    = fifo_dout_last;
                parity_d  = (^fifo_dout) ^ ODD;
                bit_cnt_d = '0;
                state_d   = S_START;
            end
            S_START:   if (tick) state_d = S_DATA;
            S_DATA: if (tick) begin
                shift_d = shift_q >> 1;
                if (bit_cnt_q == DATA_LAST) begin
                    bit_cnt_d = '0;
                    state_d   = (PARITY_EN != 0) ? S_PARITY : S_STOP;
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
            S_PARITY:  if (tick) state_d = S_STOP;
            S_STOP: if (tick) begin
                if (bit_cnt_q == STOP_LAST) begin
                    bit_cnt_d = '0;
                    state_d   = fifo_empty ? S_IDLE : S_FETCH;
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
            default:   state_d = S_IDLE;
        endcase

        // Outputs are registered, so they are decoded from the next state.
        tx_d = UART_IDLE_LEVEL;
        case (state_d)
            S_START:  tx_d = ~UART_IDLE_LEVEL;
            S_DATA:   tx_d = shift_d[0];
            S_PARITY: tx_d = parity_d;
            default:  tx_d = UART_IDLE_LEVEL;
        endcase
        rd_en_d     = (state_d == S_FETCH);
        byte_done_d = (state_q == S_STOP) && (bit_cnt_q == STOP_LAST) && (baud_cnt == CNT_PRE);
        pkt_done_d  = byte_done_d && last_q;
    end

    // NOTE: the shift register and last latch are ordinary flops, so they
    // are reset along with the control state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            last_q     <= 1'b0;
            parity_q   <= 1'b0;
            tx         <= UART_IDLE_LEVEL;
            fifo_rd_en <= 1'b0;
            byte_done  <= 1'b0;
            pkt_done   <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            last_q     <= last_d;
            parity_q   <= parity_d;
            tx         <= tx_d;
            fifo_rd_en <= rd_en_d;
            byte_done  <= byte_done_d;
            pkt_done   <= pkt_done_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer: four configurations fed by FIFO models,
// checked cycle by cycle against an expected line waveform built per frame.
module tb_uart_tx_serializer;

    localparam int CPB    = 4;
    localparam int NI     = 4;
    localparam int MASK   = 8191;
    localparam int FDEPTH = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       f_empty [NI];
    logic       f_last  [NI];
    logic       f_rd    [NI];
    logic [7:0] f_dout  [NI];
    logic       tx_s    [NI];
    logic       busy_s  [NI];
    logic       bd_s    [NI];
    logic       pd_s    [NI];

    logic [8:0] mem [NI][FDEPTH];
    int         wr_ptr [NI] = '{default: 0};
    int         rd_ptr [NI] = '{default: 0};
    int         cyc = 0;
    logic [4:0] tr [NI][MASK+1];
    int         n_checks = 0;
    int         n_fail = 0;
    logic [8:0] pend [$];

    uart_tx_serializer #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_dut0 (
        .clk(clk), .rst(rst), .fifo_empty(f_empty[0]), .fifo_rd_en(f_rd[0]), .fifo_dout(f_dout[0]),
        .fifo_dout_last(f_last[0]), .tx(tx_s[0]), .busy(busy_s[0]), .byte_done(bd_s[0]), .pkt_done(pd_s[0]));
    uart_tx_serializer #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_dut1 (
        .clk(clk), .rst(rst), .fifo_empty(f_empty[1]), .fifo_rd_en(f_rd[1]), .fifo_dout(f_dout[1]),
        .fifo_dout_last(f_last[1]), .tx(tx_s[1]), .busy(busy_s[1]), .byte_done(bd_s[1]), .pkt_done(pd_s[1]));
    uart_tx_serializer #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u_dut2 (
        .clk(clk), .rst(rst), .fifo_empty(f_empty[2]), .fifo_rd_en(f_rd[2]), .fifo_dout(f_dout[2]),
        .fifo_dout_last(f_last[2]), .tx(tx_s[2]), .busy(busy_s[2]), .byte_done(bd_s[2]), .pkt_done(pd_s[2]));
    uart_tx_serializer #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u_dut3 (
        .clk(clk), .rst(rst), .fifo_empty(f_empty[3]), .fifo_rd_en(f_rd[3]), .fifo_dout(f_dout[3]),
        .fifo_dout_last(f_last[3]), .tx(tx_s[3]), .busy(busy_s[3]), .byte_done(bd_s[3]), .pkt_done(pd_s[3]));

    // FIFO models: read data appears the cycle after a pop; empty reads are ignored.
    always_comb begin
        for (int i = 0; i < NI; i++) f_empty[i] = (rd_ptr[i] == wr_ptr[i]);
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int i = 0; i < NI; i++) begin
            if (f_rd[i] && !f_empty[i]) begin
                {f_last[i], f_dout[i]} <= mem[i][rd_ptr[i] % FDEPTH];
                rd_ptr[i] <= rd_ptr[i] + 1;
            end
        end
    end

    // Trace of {tx, rd_en, busy, byte_done, pkt_done} per cycle, sampled mid-cycle.
    always @(negedge clk) begin
        for (int i = 0; i < NI; i++)
            tr[i][cyc & MASK] <= {tx_s[i], f_rd[i], busy_s[i], bd_s[i], pd_s[i]};
    end

    function automatic int cfg_par(input int i);
        return (i == 1 || i == 2) ? 1 : 0;
    endfunction
    function automatic int cfg_odd(input int i);
        return (i == 2) ? 1 : 0;
    endfunction
    function automatic int cfg_stop(input int i);
        return (i == 3) ? 2 : 1;
    endfunction

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic push_pending(input int i);
        foreach (pend[k]) begin
            mem[i][wr_ptr[i] % FDEPTH] = pend[k];
            wr_ptr[i] = wr_ptr[i] + 1;
        end
        pend.delete();
    endtask

    // Builds the expected waveform for the staged frames, pushes them,
    // waits out the window and compares the trace.
    task automatic run_frames(input int i, input string name, output int t0);
        logic [4:0] ev [];
        int w, s, len;
        w = 9;
        foreach (pend[f]) w += (1 + 8 + cfg_par(i) + cfg_stop(i)) * CPB + 2;
        ev = new[w];
        foreach (ev[r]) ev[r] = 5'b10000;
        s = 3;
        foreach (pend[f]) begin
            logic lv [$];
            lv.push_back(1'b0);
            for (int b = 0; b < 8; b++) lv.push_back(pend[f][b]);
            if (cfg_par(i) != 0) lv.push_back((^pend[f][7:0]) ^ (cfg_odd(i) != 0));
            for (int b = 0; b < cfg_stop(i); b++) lv.push_back(1'b1);
            len = lv.size() * CPB;
            ev[s-2][3] = 1'b1;
            for (int c = s - 2; c < s + len; c++) ev[c][2] = 1'b1;
            for (int k = 0; k < len; k++) ev[s+k][4] = lv[k / CPB];
            ev[s+len-1][1] = 1'b1;
            ev[s+len-1][0] = pend[f][8];
            s += len + 2;
        end
        t0 = cyc;
        push_pending(i);
        repeat (w) step();
        for (int r = 0; r < w; r++) begin
            n_checks++;
            if (tr[i][(t0 + r) & MASK] !== ev[r]) begin
                n_fail++;
                $display("FAIL %s dut%0d cycle +%0d: tx/rd/busy/done/pkt got %b want %b",
                         name, i, r, tr[i][(t0 + r) & MASK], ev[r]);
                break;
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) step();
        for (int i = 0; i < NI; i++) begin
            n_checks++;
            if ({tx_s[i], f_rd[i], busy_s[i], bd_s[i], pd_s[i]} !== 5'b10000) begin
                n_fail++;
                $display("FAIL reset_held dut%0d: got %b want 10000", i, {tx_s[i], f_rd[i], busy_s[i], bd_s[i], pd_s[i]});
            end
        end
        rst = 1'b0;
        repeat (2) step();
        for (int i = 0; i < NI; i++) begin
            n_checks++;
            if ({tx_s[i], f_rd[i], busy_s[i], bd_s[i], pd_s[i]} !== 5'b10000) begin
                n_fail++;
                $display("FAIL reset_released dut%0d: got %b want 10000", i, {tx_s[i], f_rd[i], busy_s[i], bd_s[i], pd_s[i]});
            end
        end
    endtask

    task automatic test_single_byte();
        int t0, pops;
        pend.push_back({1'b0, 8'h55});
        run_frames(0, "single_0x55", t0);
        pops = 0;
        for (int r = 0; r < 50; r++) pops += int'(tr[0][(t0 + r) & MASK][3]);
        n_checks++;
        if (pops !== 1) begin
            n_fail++;
            $display("FAIL single_pop_count: got %0d want 1", pops);
        end
    endtask

    task automatic test_back_to_back();
        int t0;
        pend.push_back({1'b0, 8'hA3});
        pend.push_back({1'b1, 8'h0F});
        run_frames(0, "back_to_back", t0);
        // First stop ends at +42; two idle-high cycles, then start at +45.
        n_checks++;
        if ({tr[0][(t0 + 43) & MASK][4], tr[0][(t0 + 44) & MASK][4], tr[0][(t0 + 45) & MASK][4]} !== 3'b110) begin
            n_fail++;
            $display("FAIL b2b_gap: got %b want 110",
                     {tr[0][(t0 + 43) & MASK][4], tr[0][(t0 + 44) & MASK][4], tr[0][(t0 + 45) & MASK][4]});
        end
    endtask

    task automatic test_parity();
        int t0;
        pend.push_back({1'b0, 8'h07});
        run_frames(1, "parity_even", t0);
        n_checks++;
        if (tr[1][(t0 + 3 + 9 * CPB + 1) & MASK][4] !== 1'b1) begin
            n_fail++;
            $display("FAIL parity_even_slot: got %b want 1", tr[1][(t0 + 3 + 9 * CPB + 1) & MASK][4]);
        end
        pend.push_back({1'b0, 8'h07});
        run_frames(2, "parity_odd", t0);
        n_checks++;
        if (tr[2][(t0 + 3 + 9 * CPB + 1) & MASK][4] !== 1'b0) begin
            n_fail++;
            $display("FAIL parity_odd_slot: got %b want 0", tr[2][(t0 + 3 + 9 * CPB + 1) & MASK][4]);
        end
    endtask

    task automatic test_two_stop();
        int t0;
        pend.push_back({1'b1, 8'($urandom)});
        run_frames(3, "two_stop", t0);
        // byte_done only on the 8th stop cycle (+46), not the 7th (+45).
        n_checks++;
        if ({tr[3][(t0 + 45) & MASK][1], tr[3][(t0 + 46) & MASK][1]} !== 2'b01) begin
            n_fail++;
            $display("FAIL two_stop_done: got %b want 01", {tr[3][(t0 + 45) & MASK][1], tr[3][(t0 + 46) & MASK][1]});
        end
    endtask

    task automatic test_random();
        int t0, i, n;
        for (int it = 0; it < 8; it++) begin
            i = $urandom_range(0, NI - 1);
            n = $urandom_range(1, 3);
            for (int k = 0; k < n; k++) pend.push_back({1'($urandom_range(0, 1)), 8'($urandom)});
            run_frames(i, "random", t0);
            repeat ($urandom_range(0, 4)) step();
        end
    endtask

    task automatic test_empty();
        logic bad;
        bad = 1'b0;
        for (int c = 0; c < 100 && !bad; c++) begin
            step();
            for (int i = 0; i < NI; i++) begin
                n_checks++;
                if ({tx_s[i], f_rd[i], busy_s[i]} !== 3'b100) begin
                    n_fail++;
                    bad = 1'b1;
                    $display("FAIL empty_idle dut%0d cycle %0d: tx/rd/busy got %b want 100", i, c, {tx_s[i], f_rd[i], busy_s[i]});
                end
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        int t0;
        pend.push_back({1'b1, 8'h00});
        t0 = cyc;
        push_pending(0);
        repeat (20) step();
        // Now inside data bit 3 (cycles +19..+22).
        n_checks++;
        if (tx_s[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL midframe_before_rst: tx got %b want 0", tx_s[0]);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if ({tx_s[0], busy_s[0]} !== 2'b10) begin
            n_fail++;
            $display("FAIL midframe_async_rst: tx/busy got %b want 10", {tx_s[0], busy_s[0]});
        end
        repeat (3) step();
        rst = 1'b0;
        repeat (60) step();
        for (int r = 21; r < cyc - t0; r++) begin
            n_checks++;
            if (tr[0][(t0 + r) & MASK] !== 5'b10000) begin
                n_fail++;
                $display("FAIL midframe_after_rst cycle +%0d: got %b want 10000", r, tr[0][(t0 + r) & MASK]);
                break;
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_parity();
        test_two_stop();
        test_random();
        test_empty();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
